// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port LEGv8 register file with XZR, write bypass and busy scoreboard
module register_file_mp #(
   parameter int WIDTH       = 64,
   parameter int DEPTH       = 32,
   parameter int READ_PORTS  = 2,
   parameter int WRITE_PORTS = 1,
   parameter int ZERO_REG    = 31,
   parameter int BYPASS      = 1,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [READ_PORTS*AW-1:0]       read_reg,
   output logic [READ_PORTS*WIDTH-1:0]    read_data,
   output logic [READ_PORTS-1:0]          read_busy,
   input  logic [WRITE_PORTS-1:0]         reg_write,
   input  logic [WRITE_PORTS*AW-1:0]      write_reg,
   input  logic [WRITE_PORTS*WIDTH-1:0]   write_data,
   input  logic                           reserve_en,
   input  logic [AW-1:0]                  reserve_reg,
   output logic [AW:0]                    busy_count
);

   logic [WIDTH-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0] r_busy;
   logic [AW:0]      r_busy_count;

   logic [DEPTH-1:0] w_wr_en;
   logic [WIDTH-1:0] w_wr_val [DEPTH];
   logic [DEPTH-1:0] w_rsv_vec;
   logic [DEPTH-1:0] w_busy_next;
   logic [AW:0]      w_busy_next_count;

   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (int'(a) < DEPTH) && (int'(a) != ZERO_REG);
   endfunction

   // Per-register write decode; ports are scanned upward so the higher index wins.
   always_comb begin
      w_wr_en = '0;
      for (int r = 0; r < DEPTH; r++) begin
         w_wr_val[r] = '0;
      end
      for (int j = 0; j < WRITE_PORTS; j++) begin
         if (reg_write[j] && addr_ok(write_reg[j*AW +: AW])) begin
            w_wr_en[write_reg[j*AW +: AW]]  = 1'b1;
            w_wr_val[write_reg[j*AW +: AW]] = write_data[j*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      w_rsv_vec = '0;
      if (reserve_en && addr_ok(reserve_reg)) begin
         w_rsv_vec[reserve_reg] = 1'b1;
      end
      // A reserve in the same cycle as a write means a newer producer is pending.
      w_busy_next = (r_busy & ~w_wr_en) | w_rsv_vec;
      w_busy_next_count = '0;
      for (int r = 0; r < DEPTH; r++) begin
         w_busy_next_count = w_busy_next_count + (AW+1)'(w_busy_next[r]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < DEPTH; r++) begin
            r_regs[r] <= '0;
         end
         r_busy       <= '0;
         r_busy_count <= '0;
      end else begin
         for (int r = 0; r < DEPTH; r++) begin
            if (w_wr_en[r]) begin
               r_regs[r] <= w_wr_val[r];
            end
         end
         r_busy       <= w_busy_next;
         r_busy_count <= w_busy_next_count;
      end
   end

   always_comb begin
      read_data = '0;
      read_busy = '0;
      for (int i = 0; i < READ_PORTS; i++) begin
         if (addr_ok(read_reg[i*AW +: AW])) begin
            read_data[i*WIDTH +: WIDTH] = r_regs[read_reg[i*AW +: AW]];
            read_busy[i]                = r_busy[read_reg[i*AW +: AW]];
            if ((BYPASS != 0) && w_wr_en[read_reg[i*AW +: AW]]) begin
               read_data[i*WIDTH +: WIDTH] = w_wr_val[read_reg[i*AW +: AW]];
               read_busy[i]                = w_rsv_vec[read_reg[i*AW +: AW]];
            end
         end
      end
   end

   assign busy_count = r_busy_count;

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - directed-vector bench for register_file_mp (2-write bypass and no-bypass builds)
module tb_register_file_mp;

   logic clk;
   logic rst_n;

   logic [9:0]   a_read_reg;
   logic [127:0] a_read_data;
   logic [1:0]   a_read_busy;
   logic [1:0]   a_reg_write;
   logic [9:0]   a_write_reg;
   logic [127:0] a_write_data;
   logic         a_reserve_en;
   logic [4:0]   a_reserve_reg;
   logic [5:0]   a_busy_count;

   logic [9:0]   b_read_reg;
   logic [127:0] b_read_data;
   logic [1:0]   b_read_busy;
   logic [0:0]   b_reg_write;
   logic [4:0]   b_write_reg;
   logic [63:0]  b_write_data;
   logic         b_reserve_en;
   logic [4:0]   b_reserve_reg;
   logic [5:0]   b_busy_count;

   int n_vec;
   int n_miss;

   register_file_mp #(.WRITE_PORTS(2), .BYPASS(1)) u_dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .read_reg    (a_read_reg),
      .read_data   (a_read_data),
      .read_busy   (a_read_busy),
      .reg_write   (a_reg_write),
      .write_reg   (a_write_reg),
      .write_data  (a_write_data),
      .reserve_en  (a_reserve_en),
      .reserve_reg (a_reserve_reg),
      .busy_count  (a_busy_count)
   );

   register_file_mp #(.WRITE_PORTS(1), .BYPASS(0)) u_dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .read_reg    (b_read_reg),
      .read_data   (b_read_data),
      .read_busy   (b_read_busy),
      .reg_write   (b_reg_write),
      .write_reg   (b_write_reg),
      .write_data  (b_write_data),
      .reserve_en  (b_reserve_en),
      .reserve_reg (b_reserve_reg),
      .busy_count  (b_busy_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_rd(input logic [4:0] r0, input logic [4:0] r1);
      a_read_reg = {r1, r0};
   endtask

   task automatic a_wr(input int p, input logic [4:0] r, input logic [63:0] d);
      a_reg_write[p]           = 1'b1;
      a_write_reg[p*5 +: 5]    = r;
      a_write_data[p*64 +: 64] = d;
   endtask

   task automatic idle();
      a_reg_write  = '0;
      a_reserve_en = 1'b0;
      b_reg_write  = '0;
      b_reserve_en = 1'b0;
   endtask

   initial begin
      clk = 1'b0;
      rst_n = 1'b0;
      n_vec = 0;
      n_miss = 0;
      a_read_reg = '0; a_reg_write = '0; a_write_reg = '0; a_write_data = '0;
      a_reserve_en = 1'b0; a_reserve_reg = '0;
      b_read_reg = '0; b_reg_write = '0; b_write_reg = '0; b_write_data = '0;
      b_reserve_en = 1'b0; b_reserve_reg = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int r = 0; r < 32; r += 2) begin
         a_rd(5'(r), 5'(r + 1));
         #1;
         check("rst_rd0", a_read_data[63:0], 64'd0);
         check("rst_rd1", a_read_data[127:64], 64'd0);
         check("rst_busy", 64'(a_read_busy), 64'd0);
      end
      check("rst_count", 64'(a_busy_count), 64'd0);

      // Asynchronous reset clears state without a clock edge.
      a_wr(0, 5'd5, 64'd77);
      tick();
      idle();
      a_rd(5'd5, 5'd0);
      #1;
      check("x5_pre_rst", a_read_data[63:0], 64'd77);
      rst_n = 1'b0;
      #1;
      check("x5_async_rst", a_read_data[63:0], 64'd0);
      #2 rst_n = 1'b1;

      // Single write X11=100: bypass on A, delayed visibility on B.
      a_wr(0, 5'd11, 64'd100);
      a_rd(5'd11, 5'd0);
      b_reg_write = 1'b1; b_write_reg = 5'd11; b_write_data = 64'd100;
      b_read_reg = {5'd0, 5'd11};
      #1;
      check("x11_bypass", a_read_data[63:0], 64'd100);
      check("x11_nobypass_old", b_read_data[63:0], 64'd0);
      tick();
      idle();
      #1;
      check("x11_after_a", a_read_data[63:0], 64'd100);
      check("x11_after_b", b_read_data[63:0], 64'd100);

      // Same-register dual write: port 1 wins for bypass and storage.
      a_wr(0, 5'd3, 64'd1);
      a_wr(1, 5'd3, 64'd2);
      a_rd(5'd3, 5'd3);
      #1;
      check("x3_dual_bypass", a_read_data[63:0], 64'd2);
      tick();
      idle();
      #1;
      check("x3_dual_stored", a_read_data[127:64], 64'd2);

      a_wr(0, 5'd4, 64'h1_2345_6789);
      a_wr(1, 5'd7, 64'd5);
      tick();
      idle();
      a_rd(5'd4, 5'd7);
      #1;
      check("x4_wide", a_read_data[63:0], 64'h1_2345_6789);
      check("x7_port1", a_read_data[127:64], 64'd5);

      // XZR ignores writes and reserves.
      a_wr(0, 5'd31, 64'hFFFF);
      a_reserve_en = 1'b1; a_reserve_reg = 5'd31;
      a_rd(5'd31, 5'd31);
      #1;
      check("xzr_bypass0", a_read_data[63:0], 64'd0);
      check("xzr_bypass1", a_read_data[127:64], 64'd0);
      check("xzr_busy_cyc", 64'(a_read_busy), 64'd0);
      tick();
      idle();
      #1;
      check("xzr_after", a_read_data[63:0], 64'd0);
      check("xzr_busy_after", 64'(a_read_busy), 64'd0);
      check("xzr_count", 64'(a_busy_count), 64'd0);

      // Reserve X9, then the producer writes it back.
      a_reserve_en = 1'b1; a_reserve_reg = 5'd9;
      tick();
      idle();
      a_rd(5'd9, 5'd0);
      #1;
      check("x9_busy", 64'(a_read_busy[0]), 64'd1);
      check("x9_count", 64'(a_busy_count), 64'd1);
      a_wr(0, 5'd9, 64'd42);
      #1;
      check("x9_wb_bypass", a_read_data[63:0], 64'd42);
      check("x9_wb_busy", 64'(a_read_busy[0]), 64'd0);
      tick();
      idle();
      #1;
      check("x9_clear_busy", 64'(a_read_busy[0]), 64'd0);
      check("x9_clear_count", 64'(a_busy_count), 64'd0);
      check("x9_data", a_read_data[63:0], 64'd42);

      // Same-cycle reserve and write of X2 leaves it busy.
      a_wr(0, 5'd2, 64'd8);
      a_reserve_en = 1'b1; a_reserve_reg = 5'd2;
      a_rd(5'd2, 5'd0);
      #1;
      check("x2_cyc_data", a_read_data[63:0], 64'd8);
      check("x2_cyc_busy", 64'(a_read_busy[0]), 64'd1);
      tick();
      idle();
      #1;
      check("x2_data", a_read_data[63:0], 64'd8);
      check("x2_busy", 64'(a_read_busy[0]), 64'd1);
      check("x2_count", 64'(a_busy_count), 64'd1);
      a_reserve_en = 1'b1; a_reserve_reg = 5'd2;
      tick();
      idle();
      check("x2_rereserve_count", 64'(a_busy_count), 64'd1);

      for (int r = 1; r <= 30; r++) begin
         a_reserve_en = 1'b1; a_reserve_reg = 5'(r);
         tick();
      end
      a_reserve_reg = 5'd31;
      tick();
      idle();
      check("count_30", 64'(a_busy_count), 64'd30);

      a_wr(1, 5'd1, 64'd3);
      tick();
      idle();
      a_rd(5'd1, 5'd30);
      #1;
      check("count_29", 64'(a_busy_count), 64'd29);
      check("x1_cleared", 64'(a_read_busy), 64'b10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port LEGv8 register file for the next-generation datapath, replacing the fixed 2-read/1-write register memory.
- Provides N combinational read ports, M synchronous write ports, hardwired XZR, optional write-to-read bypass, and a per-register busy scoreboard for multi-cycle/pipelined producers.
- Sits between decode (read/reserve) and writeback (write).
- Single clock; the separate read/write clock scheme is dropped.

Parameters:
- WIDTH, 64, data word width in bits.
- DEPTH, 32, number of architectural registers; AW = $clog2(DEPTH).
- READ_PORTS, 2, number of read ports (1..4).
- WRITE_PORTS, 1, number of write ports (1..2).
- ZERO_REG, 31, register index that always reads 0 and ignores writes and reserves; DEPTH disables this.
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching reads.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- read_reg  input  READ_PORTS*AW  flattened read addresses; port i = bits [i*AW +: AW].
- read_data  output  READ_PORTS*WIDTH  flattened read data.
- read_busy  output  READ_PORTS  scoreboard busy bit of each read address.
- reg_write  input  WRITE_PORTS  per-port write enable.
- write_reg  input  WRITE_PORTS*AW  flattened write addresses.
- write_data  input  WRITE_PORTS*WIDTH  flattened write data.
- reserve_en  input  1  mark a destination register busy.
- reserve_reg  input  AW  register to reserve.
- busy_count  output  AW+1  number of currently busy registers.

Behaviour:
- Reset: while rst_n=0, all registers = 0 and all busy bits = 0.
  - read_data therefore = 0 and read_busy = 0; busy_count = 0.
  - Reset asserted mid-operation discards any in-flight write at that edge.
- Reads are combinational from registered state, zero-cycle latency.
  - read_reg == ZERO_REG always returns 0 and read_busy = 0, regardless of writes or bypass.
  - Addresses >= DEPTH (when DEPTH is not a power of 2) return 0 and read_busy = 0.
- Writes:
  - On rising clk with reg_write[j]=1, register write_reg[j] <= write_data[j].
  - Writes to ZERO_REG or to addresses >= DEPTH are ignored.
  - Two write ports targeting the same register in one cycle: the higher port index wins. This applies to both stored data and bypass.
- Bypass (BYPASS=1):
  - If any enabled write port targets read_reg[i] (not ZERO_REG) in the current cycle, read_data[i] = the winning write_data, combinationally.
  - read_busy[i] = 0 in that case, unless reserve_en targets the same register this cycle.
- BYPASS=0: reads see the new value only from the cycle after the write edge.
- Scoreboard:
  - Rising clk with reserve_en=1 sets busy[reserve_reg]. Reserving ZERO_REG is ignored.
  - Rising clk with any enabled write to register r clears busy[r].
  - Same-cycle reserve and write to the same r: busy[r] ends at 1 and data is written (new producer supersedes old).
  - Reserving an already busy register keeps it busy (no counting).
- busy_count:
  - Registered popcount of the busy vector, updated at the same edge as the busy bits.
  - Range 0..DEPTH-1 (ZERO_REG is never busy).
- No X on outputs after reset for any legal input.
- Port widths scale with parameters; no truncation of write_data.

Test Plan:
- Reset then read all registers via ports 0 and 1 -> every read_data = 0, read_busy = 0, busy_count = 0. Assert rst_n=0 for 3 ns mid-cycle after writing X5=77 -> X5 reads 0 immediately, without a clock edge.
- Write X11=100 on port 0, next cycle read_reg0=11 -> read_data0=100. Same-cycle read with BYPASS=1 -> 100 during the write cycle. BYPASS=0 build -> old value 0 during the write cycle, 100 after.
- WRITE_PORTS=2: same cycle, port0 writes X3=1 and port1 writes X3=2 -> X3 reads 2. Port0 writes X4=0x123456789 and port1 writes X7=5 -> both read back correctly.
- Write X31=0xFFFF and reserve X31 -> read X31 = 0, read_busy=0, busy_count unchanged. Read X31 on all ports while a write to 31 is asserted -> still 0.
- Reserve X9, next cycle read X9 -> read_busy=1, busy_count=1. Write X9=42 -> same-cycle bypass gives 42 with read_busy=0; next cycle busy=0, busy_count=0.
- Reserve X2 and write X2=8 in the same cycle -> X2 reads 8, read_busy=1, busy_count=1. Reserve X2 again -> busy_count stays 1. Reserve X1..X30 over 30 cycles -> busy_count=30.
